fp_multiplier_iter: RTL
=======================

# fp_multiplier_iter

Parametrised, multi-cycle IEEE-754-style floating-point multiplier. It generalises the single-precision combinational multiplier to any exponent/significand width, and adds a valid/ready handshake, an iterative shift-add significand multiplier, normalisation, guard/round/sticky rounding, special-value handling and exception flags. It sits between the FPU operand registers and the result writeback stage, and holds one operation in flight.

## Interface
- EXP_W, 8, exponent width; bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored significand width (hidden bit excluded)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- a, b  in  EXP_W+MAN_W+1  operands: {sign, exponent, significand}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  EXP_W+MAN_W+1  product
- flags  out  4  {invalid, overflow, underflow, inexact}; valid with out_valid

## Operation
- States: IDLE, MULT, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, the block latches the operands.
  - Special operands go directly to DONE.
  - All other operands go to MULT with count=0.
- Special cases (exp==0 means zero; denormals flush to zero):
  - any NaN, or inf×0: result={0, all-ones, 1, 0…}; invalid=1
  - inf×finite or inf×inf: result=signed inf
  - zero×finite: result=signed zero
- Result sign is always sign_a XOR sign_b.
- MULT: shift-add over {1,man_a}×{1,man_b}, one multiplier bit per cycle, MAN_W+1 cycles. Accumulator is 2·(MAN_W+1) bits.
- Exponent: exp_a+exp_b−bias, computed as a signed value of EXP_W+2 bits. It is computed at accept time.
- NORM: if product MSB=1, shift right by 1 and exp+1.
- Rounding bits: G = first discarded bit, R = second, S = OR of the remaining discarded bits.
- ROUND:
  - Apply the rounding rule (see Configuration).
  - If significand carry-out occurs, shift right and exp+1.
  - If exp ≥ 2^EXP_W−1: result=signed inf; overflow=1; inexact=1.
  - If exp ≤ 0: result=signed zero; underflow=1; inexact=1.
  - inexact = G|R|S in all other cases.
- DONE: out_valid=1. result and flags are held stable until out_ready. On out_valid&&out_ready, go to IDLE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0.
- Reset mid-operation discards the operation. No output is produced.
- in_valid outside IDLE is ignored. Operands are not sampled.

## Timing
- Normal operands: out_valid rises MAN_W+4 edges after the accepting edge (27 at defaults).
  - 1 edge to enter MULT.
  - MAN_W+1 MULT edges.
  - 1 NORM edge.
  - 1 ROUND edge.
- Special operands: out_valid rises 1 edge after the accepting edge.
- Result handshake completes on the edge with out_valid&&out_ready. IDLE (in_ready=1) follows on that edge.
- The earliest next accept is the following edge. Minimum issue interval is MAN_W+6 cycles.
- out_ready held low: the block stays in DONE indefinitely; outputs do not change.
- in_ready is 0 from the accepting edge until the DONE handshake.

## Configuration
- FP_MULT_RNE_EN defined: round-to-nearest-even. Increment when G&(R|S|lsb).
- FP_MULT_RNE_EN undefined: truncation (round toward zero). No increment; the round-carry path is removed.
- inexact, overflow and underflow detection are identical in both builds. Overflow in truncate mode still returns inf.

## Test plan
- 0x3FC00000 × 0x40000000 -> result 0x40400000, flags 0, out_valid exactly 27 cycles after accept.
- 0x3FC00001 × 0x3FC00001 -> 0x40100002 with FP_MULT_RNE_EN; 0x40100001 without it; inexact=1 in both builds.
- 0x7F000000 × 0x7F000000 -> 0x7F800000, overflow=1, inexact=1.
- 0x00800000 × 0x00800000 -> 0x00000000, underflow=1, inexact=1.
- 0x7F800000 × 0x80000000 -> 0x7FC00000, invalid=1, out_valid 1 cycle after accept.
- Backpressure and reset:
  - With out_ready=0 for 10 cycles, result and flags stay stable and in_ready stays 0; the handshake completes when out_ready rises.
  - Asserting reset mid-MULT gives out_valid=0, in_ready=1 and result=0 immediately; the next operation completes normally.

Source files
------------

// File: rtl/fp_multiplier_iter.sv
// Multi-cycle parametrised floating-point multiplier with valid/ready handshake.
// Define FP_MULT_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_multiplier_iter #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     a,
    input  logic [EXP_W+MAN_W:0]     b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [3:0]               flags
);

    localparam int unsigned W  = EXP_W + MAN_W + 1;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned CW = $clog2(MAN_W + 2);

    localparam logic signed [EW-1:0] Bias   = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] ExpOne = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]        LastCount = CW'(MAN_W);

    typedef enum logic [2:0] {StIdle, StMult, StNorm, StRound, StDone} state_t;

    state_t                 state;
    logic                   sign_q;
    logic signed [EW-1:0]   exp_q;
    logic [PW-1:0]          acc;
    logic [PW-1:0]          mcand;
    logic [SW-1:0]          mplier;
    logic [CW-1:0]          count;

    // Operand decode
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             sign_in;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special;
    logic signed [EW-1:0] exp_in;
    logic [W-1:0]     spec_res;
    logic [3:0]       spec_flags;

    assign ea      = a[W-2 -: EXP_W];
    assign eb      = b[W-2 -: EXP_W];
    assign ma      = a[MAN_W-1:0];
    assign mb      = b[MAN_W-1:0];
    assign sign_in = a[W-1] ^ b[W-1];
    assign a_zero  = ~|ea;
    assign b_zero  = ~|eb;
    assign a_nan   = (&ea) & (|ma);
    assign b_nan   = (&eb) & (|mb);
    assign a_inf   = (&ea) & ~(|ma);
    assign b_inf   = (&eb) & ~(|mb);
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign exp_in  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - Bias;

    always_comb begin
        spec_res   = '0;
        spec_flags = 4'b0000;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_res   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            spec_flags = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_res = {sign_in, {(W-1){1'b0}}};
        end
    end

    // Rounding on the normalised product: leading one sits at acc[PW-1]
    logic                 g_bit, r_bit, s_bit;
    logic [MAN_W-1:0]     man_r;
    logic signed [EW-1:0] exp_r;
    logic                 ovf, unf;

    assign g_bit = acc[MAN_W];
    assign r_bit = acc[MAN_W-1];
    assign s_bit = |acc[MAN_W-2:0];

`ifdef FP_MULT_RNE_EN
    logic [SW-1:0] sig;
    logic          inc;
    logic [SW:0]   sum;

    assign sig   = acc[PW-1 -: SW];
    assign inc   = g_bit & (r_bit | s_bit | sig[0]);
    assign sum   = {1'b0, sig} + {{SW{1'b0}}, inc};
    // Carry-out leaves 10...0; shifting right keeps a zero stored significand
    assign man_r = sum[SW] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    assign exp_r = exp_q + (sum[SW] ? ExpOne : '0);
`else
    assign man_r = acc[PW-2 -: MAN_W];
    assign exp_r = exp_q;
`endif

    assign ovf = (exp_r >= ExpMax);
    assign unf = exp_r[EW-1] | ~|exp_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= 4'b0000;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        sign_q   <= sign_in;
                        if (special) begin
                            result    <= spec_res;
                            flags     <= spec_flags;
                            out_valid <= 1'b1;
                            state     <= StDone;
                        end else begin
                            exp_q  <= exp_in;
                            acc    <= '0;
                            mcand  <= {{SW{1'b0}}, 1'b1, ma};
                            mplier <= {1'b1, mb};
                            count  <= '0;
                            state  <= StMult;
                        end
                    end
                end
                StMult: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LastCount) begin
                        state <= StNorm;
                    end
                end
                StNorm: begin
                    // Left-align instead of right-shifting so no discarded bit is lost
                    if (acc[PW-1]) begin
                        exp_q <= exp_q + ExpOne;
                    end else begin
                        acc <= acc << 1;
                    end
                    state <= StRound;
                end
                StRound: begin
                    if (ovf) begin
                        result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        flags  <= 4'b0101;
                    end else if (unf) begin
                        result <= {sign_q, {(W-1){1'b0}}};
                        flags  <= 4'b0011;
                    end else begin
                        result <= {sign_q, exp_r[EXP_W-1:0], man_r};
                        flags  <= {3'b000, g_bit | r_bit | s_bit};
                    end
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
